// File: rtl/beep_pkg.sv
// Shared types and constants for the beep scheduler.
// Holds the phase enum, the grant source codes and the 1 ms tick constant.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_KEY   = 2'd1,
        SRC_CHIME = 2'd2,
        SRC_ALARM = 2'd3
    } src_t;

    localparam int MS_PER_SEC = 1000;

    function automatic int tick_div(input int clk_hz);
        return clk_hz / MS_PER_SEC;
    endfunction

endpackage

// File: rtl/beep_tick_gen.sv
// Millisecond prescaler: pulses tick once every DIV clocks.
// restart clears the count so a new phase starts on a clean ms boundary.
module beep_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Free-running divide counter, zeroed on restart or wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/beep_scheduler.sv
// Arbitrates key-click, hourly chime and alarm beep patterns onto one beep line.
// Alarm beats chime beats key; phase timing comes from a restartable ms tick.
module beep_scheduler
    import beep_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int KEY_MS       = 30,
    parameter int CHIME_ON_MS  = 200,
    parameter int CHIME_OFF_MS = 200,
    parameter int ALARM_ON_MS  = 100,
    parameter int ALARM_OFF_MS = 100,
    parameter int ALARM_GAP_MS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_key,
    input  logic       req_chime,
    input  logic [3:0] chime_count,
    input  logic       alarm_active,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [1:0] grant
);

    localparam int TICK_DIV = tick_div(CLK_HZ);

    localparam logic [15:0] KEY_LAST       = 16'(KEY_MS - 1);
    localparam logic [15:0] CHIME_ON_LAST  = 16'(CHIME_ON_MS - 1);
    localparam logic [15:0] CHIME_OFF_LAST = 16'(CHIME_OFF_MS - 1);
    localparam logic [15:0] ALARM_ON_LAST  = 16'(ALARM_ON_MS - 1);
    localparam logic [15:0] ALARM_OFF_LAST = 16'(ALARM_OFF_MS - 1);
    localparam logic [15:0] ALARM_GAP_LAST = 16'(ALARM_GAP_MS - 1);

    state_t      state, state_n;
    src_t        src, src_n;
    logic [15:0] ms_cnt;
    logic [3:0]  beep_left, beep_left_n;
    logic [1:0]  burst_idx, burst_idx_n;
    logic        pend_key, pend_key_n;
    logic        pend_chime, pend_chime_n;

    logic        tick;
    logic        restart;
    logic        discard;
    logic        done;
    logic [15:0] last;

    beep_tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    // Pick the final ms index of the current phase.
    always_comb begin
        last = KEY_LAST;
        unique case (state)
            ST_ON: begin
                if (src == SRC_CHIME) begin
                    last = CHIME_ON_LAST;
                end else if (src == SRC_ALARM) begin
                    last = ALARM_ON_LAST;
                end else begin
                    last = KEY_LAST;
                end
            end
            ST_OFF:  last = (src == SRC_CHIME) ? CHIME_OFF_LAST : ALARM_OFF_LAST;
            ST_GAP:  last = ALARM_GAP_LAST;
            default: last = KEY_LAST;
        endcase
    end

    assign done = tick && (ms_cnt == last);

    // Next phase, source, counters and pending requests.
    always_comb begin
        state_n     = state;
        src_n       = src;
        beep_left_n = beep_left;
        burst_idx_n = burst_idx;
        restart     = 1'b0;

        // Requests landing while the alarm keeps sounding are dropped.
        discard      = (state != ST_IDLE) && (src == SRC_ALARM) && alarm_active;
        pend_key_n   = pend_key | (req_key & ~discard);
        pend_chime_n = pend_chime | (req_chime & ~discard);

        if (state == ST_IDLE) begin
            restart = 1'b1;
            if (alarm_active) begin
                state_n     = ST_ON;
                src_n       = SRC_ALARM;
                burst_idx_n = 2'd0;
            end else if (pend_chime) begin
                state_n      = ST_ON;
                src_n        = SRC_CHIME;
                beep_left_n  = chime_count;
                pend_chime_n = 1'b0;
            end else if (pend_key) begin
                state_n    = ST_ON;
                src_n      = SRC_KEY;
                pend_key_n = 1'b0;
            end
        end else if (src == SRC_ALARM) begin
            if (!alarm_active) begin
                state_n = ST_IDLE;
                src_n   = SRC_NONE;
                restart = 1'b1;
            end else if (done) begin
                restart = 1'b1;
                unique case (state)
                    ST_ON: begin
                        state_n = (burst_idx == 2'd3) ? ST_GAP : ST_OFF;
                    end
                    ST_OFF: begin
                        state_n     = ST_ON;
                        burst_idx_n = burst_idx + 2'd1;
                    end
                    ST_GAP: begin
                        state_n     = ST_ON;
                        burst_idx_n = 2'd0;
                    end
                    default: begin
                        state_n = ST_IDLE;
                        src_n   = SRC_NONE;
                    end
                endcase
            end
        end else if (alarm_active) begin
            state_n     = ST_ON;
            src_n       = SRC_ALARM;
            burst_idx_n = 2'd0;
            restart     = 1'b1;
        end else if (src == SRC_CHIME && state == ST_ON && beep_left == 4'd0) begin
            // Zero-count chime: one silent ON cycle, then done.
            state_n = ST_IDLE;
            src_n   = SRC_NONE;
            restart = 1'b1;
        end else if (done) begin
            restart = 1'b1;
            if (src == SRC_CHIME && state == ST_ON) begin
                beep_left_n = beep_left - 4'd1;
                if (beep_left == 4'd1) begin
                    state_n = ST_IDLE;
                    src_n   = SRC_NONE;
                end else begin
                    state_n = ST_OFF;
                end
            end else if (src == SRC_CHIME) begin
                state_n = ST_ON;
            end else begin
                state_n = ST_IDLE;
                src_n   = SRC_NONE;
            end
        end
    end

    // Phase and pattern registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            src        <= SRC_NONE;
            ms_cnt     <= '0;
            beep_left  <= '0;
            burst_idx  <= '0;
            pend_key   <= 1'b0;
            pend_chime <= 1'b0;
        end else begin
            state      <= state_n;
            src        <= src_n;
            beep_left  <= beep_left_n;
            burst_idx  <= burst_idx_n;
            pend_key   <= pend_key_n;
            pend_chime <= pend_chime_n;
            if (restart) begin
                ms_cnt <= '0;
            end else if (tick) begin
                ms_cnt <= ms_cnt + 16'd1;
            end
        end
    end

    // Registered outputs follow the phase being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep  <= 1'b0;
            busy  <= 1'b0;
            grant <= 2'd0;
        end else begin
            beep  <= (state_n == ST_ON) && !mute &&
                     !(src_n == SRC_CHIME && beep_left_n == 4'd0);
            busy  <= (state_n != ST_IDLE);
            grant <= src_n;
        end
    end

endmodule

// File: tb/tb_beep_scheduler.sv
// Self-checking bench for beep_scheduler: directed vector table,
// async reset sequence and random traffic against a pattern-queue model.
module tb_beep_scheduler;

    localparam int CLK_HZ = 4000;
    localparam int TD     = CLK_HZ / 1000;
    localparam int KEY_MS = 3;
    localparam int CON_MS = 2;
    localparam int COF_MS = 2;
    localparam int AON_MS = 1;
    localparam int AOF_MS = 1;
    localparam int AGP_MS = 5;

    logic       clk;
    logic       rst;
    logic       req_key;
    logic       req_chime;
    logic [3:0] chime_count;
    logic       alarm_active;
    logic       mute;
    logic       beep;
    logic       busy;
    logic [1:0] grant;

    int n_checks;
    int n_fail;

    beep_scheduler #(
        .CLK_HZ      (CLK_HZ),
        .KEY_MS      (KEY_MS),
        .CHIME_ON_MS (CON_MS),
        .CHIME_OFF_MS(COF_MS),
        .ALARM_ON_MS (AON_MS),
        .ALARM_OFF_MS(AOF_MS),
        .ALARM_GAP_MS(AGP_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_key     (req_key),
        .req_chime   (req_chime),
        .chime_count (chime_count),
        .alarm_active(alarm_active),
        .mute        (mute),
        .beep        (beep),
        .busy        (busy),
        .grant       (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the active pattern is a queue of per-clock
    // levels (0 silent gap, 1 audible on, 2 on but silent).
    int mq[$];
    bit m_act;
    int m_src;
    bit m_pk;
    bit m_pc;
    bit e_beep;
    bit e_busy;
    int e_grant;

    task automatic model_reset();
        mq.delete();
        m_act = 0;
        m_src = 0;
        m_pk  = 0;
        m_pc  = 0;
    endtask

    task automatic push_n(input int val, input int len);
        for (int i = 0; i < len; i++) mq.push_back(val);
    endtask

    task automatic push_burst();
        for (int b = 0; b < 4; b++) begin
            push_n(1, AON_MS * TD);
            push_n(0, (b == 3) ? AGP_MS * TD : AOF_MS * TD);
        end
    endtask

    task automatic start_alarm();
        mq.delete();
        m_act = 1;
        m_src = 3;
        push_burst();
    endtask

    task automatic start_chime(input int n);
        mq.delete();
        m_act = 1;
        m_src = 2;
        if (n == 0) begin
            push_n(2, 1);
        end else begin
            for (int i = 0; i < n; i++) begin
                push_n(1, CON_MS * TD);
                if (i < n - 1) push_n(0, COF_MS * TD);
            end
        end
    endtask

    task automatic start_key();
        mq.delete();
        m_act = 1;
        m_src = 1;
        push_n(1, KEY_MS * TD);
    endtask

    task automatic model_step();
        bit disc;
        bit npk;
        bit npc;
        if (rst) begin
            model_reset();
        end else begin
            disc = m_act && m_src == 3 && alarm_active;
            npk  = m_pk | (req_key && !disc);
            npc  = m_pc | (req_chime && !disc);
            if (!m_act) begin
                if (alarm_active) begin
                    start_alarm();
                end else if (m_pc) begin
                    start_chime(int'(chime_count));
                    npc = 0;
                end else if (m_pk) begin
                    start_key();
                    npk = 0;
                end
            end else if (m_src == 3 && !alarm_active) begin
                m_act = 0;
                mq.delete();
            end else if (m_src != 3 && alarm_active) begin
                start_alarm();
            end else begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    if (m_src == 3) push_burst();
                    else m_act = 0;
                end
            end
            m_pk = npk;
            m_pc = npc;
        end
        e_busy  = m_act;
        e_grant = m_act ? m_src : 0;
        e_beep  = m_act && mq.size() > 0 && mq[0] == 1 && !mute;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rk, input bit rc, input int cc,
                       input bit al, input bit mu);
        req_key      = rk;
        req_chime    = rc;
        chime_count  = 4'(cc);
        alarm_active = al;
        mute         = mu;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit rk;
        bit rc;
        int cc;
        bit al;
        bit mu;
        int n;
        bit eb;
        bit ebusy;
        int eg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit rk, bit rc, int cc, bit al, bit mu,
                               int n, bit eb, bit ebusy, int eg);
        vec_t r;
        r.rk = rk; r.rc = rc; r.cc = cc; r.al = al; r.mu = mu;
        r.n = n; r.eb = eb; r.ebusy = ebusy; r.eg = eg;
        return r;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        req_key = 0; req_chime = 0; chime_count = 0;
        alarm_active = 0; mute = 0;
        model_reset();

        // Key click: pend, 12 high, idle.
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 12, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 0, 0, 0));
        // Chime x3.
        tbl.push_back(v(0, 1, 3, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 3, 0, 0, 8, 1, 1, 2));
        tbl.push_back(v(0, 0, 3, 0, 0, 8, 0, 1, 2));
        tbl.push_back(v(0, 0, 3, 0, 0, 8, 1, 1, 2));
        tbl.push_back(v(0, 0, 3, 0, 0, 8, 0, 1, 2));
        tbl.push_back(v(0, 0, 3, 0, 0, 8, 1, 1, 2));
        tbl.push_back(v(0, 0, 3, 0, 0, 2, 0, 0, 0));
        // Chime x0: busy one silent clock.
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 2));
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 0, 0, 0));
        // Alarm burst, gap and wrap, then release.
        for (int b = 0; b < 4; b++) begin
            tbl.push_back(v(0, 0, 0, 1, 0, 4, 1, 1, 3));
            tbl.push_back(v(0, 0, 0, 1, 0, (b == 3) ? 20 : 4, 0, 1, 3));
        end
        tbl.push_back(v(0, 0, 0, 1, 0, 4, 1, 1, 3));
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 0, 0, 0));
        // Alarm preempts a chime; key during alarm is dropped.
        tbl.push_back(v(0, 1, 3, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 3, 0, 0, 5, 1, 1, 2));
        tbl.push_back(v(0, 0, 3, 1, 0, 4, 1, 1, 3));
        tbl.push_back(v(1, 0, 3, 1, 0, 4, 0, 1, 3));
        tbl.push_back(v(0, 0, 3, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 3, 0, 0, 20, 0, 0, 0));
        // Chime requested mid-click waits for the key to finish.
        tbl.push_back(v(1, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 3, 1, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 8, 1, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 8, 1, 1, 2));
        tbl.push_back(v(0, 0, 1, 0, 0, 2, 0, 0, 0));
        // Muted key: same busy/grant timing, no beep.
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 12, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_beep", int'(beep), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(grant), 0);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            for (int i = 0; i < tbl[k].n; i++) begin
                cyc(i == 0 ? tbl[k].rk : 1'b0, i == 0 ? tbl[k].rc : 1'b0,
                    tbl[k].cc, tbl[k].al, tbl[k].mu);
                chk($sformatf("vec%0d_beep", k), int'(beep), int'(tbl[k].eb));
                chk($sformatf("vec%0d_busy", k), int'(busy), int'(tbl[k].ebusy));
                chk($sformatf("vec%0d_grant", k), int'(grant), tbl[k].eg);
            end
        end

        // Reset asserted mid-alarm clears outputs without a clock edge.
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0);
        chk("pre_rst_beep", int'(beep), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_beep", int'(beep), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_grant", int'(grant), 0);
        cyc(1, 1, 2, 0, 0);
        cyc(0, 0, 2, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 2, 0, 0);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_grant", int'(grant), 0);
        end

        // Random traffic against the model.
        begin
            bit al;
            bit mu;
            al = 0;
            mu = 0;
            for (int i = 0; i < 5000; i++) begin
                if ($urandom_range(0, 299) == 0) al = ~al;
                if ($urandom_range(0, 59) == 0) mu = ~mu;
                cyc($urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0,
                    int'($urandom_range(0, 4)), al, mu);
                chk("rand_beep", int'(beep), int'(e_beep));
                chk("rand_busy", int'(busy), int'(e_busy));
                chk("rand_grant", int'(grant), e_grant);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
